// File: rtl/debug_responder.sv
// CPU-side executor for debug-port requests: runs one memory, register or CC/PC
// operation per request while the core is stopped and answers with a single ACK.
module debug_responder #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        DEBUG_MODE,
  input  logic        DEBUG_REQ,
  input  logic [3:0]  DEBUG_OP,
  input  logic [15:0] DEBUG_ADDR_OUT,
  input  logic [3:0]  DEBUG_ARGX_OUT,
  input  logic [15:0] DEBUG_DATA_OUT,
  output logic        DEBUG_ACK,
  output logic        DEBUG_LD_DATA_EN,
  output logic [1:0]  DEBUG_DATAX,
  output logic        DEBUG_ADDR_INC_EN,
  output logic [15:0] MEM_ADDR,
  output logic [15:0] MEM_DOUT,
  output logic        MEM_RD,
  output logic        MEM_WR,
  input  logic        MEM_READY,
  output logic [3:0]  REG_ADDR,
  output logic        REG_WR,
  output logic        DEBUG_ERR
);

  localparam logic [3:0] DEBUG_OPX_NONE   = 4'h0;
  localparam logic [3:0] DEBUG_OPX_WR_MEM = 4'h1;
  localparam logic [3:0] DEBUG_OPX_RD_MEM = 4'h2;
  localparam logic [3:0] DEBUG_OPX_RD_REG = 4'h3;
  localparam logic [3:0] DEBUG_OPX_WR_REG = 4'h4;
  localparam logic [3:0] DEBUG_OPX_RD_CC  = 4'h5;
  localparam logic [3:0] DEBUG_OPX_RD_PC  = 4'h6;

  localparam logic [1:0] DEBUG_DATAX_DIN       = 2'd0;
  localparam logic [1:0] DEBUG_DATAX_REGB_DATA = 2'd1;
  localparam logic [1:0] DEBUG_DATAX_CC_DATA   = 2'd2;
  localparam logic [1:0] DEBUG_DATAX_PC_A_NEXT = 2'd3;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXEC,
    S_MEMWAIT,
    S_REGWAIT,
    S_ACK,
    S_RELEASE
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        op_q, op_d;
  logic [15:0]       addr_q, addr_d;
  logic [3:0]        argx_q, argx_d;
  logic [15:0]       data_q, data_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              debug_ack_q, debug_ack_d;
  logic              ld_data_en_q, ld_data_en_d;
  logic              addr_inc_en_q, addr_inc_en_d;
  logic [1:0]        datax_q, datax_d;
  logic [15:0]       mem_addr_q, mem_addr_d;
  logic [15:0]       mem_dout_q, mem_dout_d;
  logic              mem_rd_q, mem_rd_d;
  logic              mem_wr_q, mem_wr_d;
  logic [3:0]        reg_addr_q, reg_addr_d;
  logic              reg_wr_q, reg_wr_d;
  logic              err_q, err_d;

  logic              op_is_mem;
  logic              op_is_read;

  always_comb begin
    op_is_mem  = (op_q == DEBUG_OPX_WR_MEM) || (op_q == DEBUG_OPX_RD_MEM);
    op_is_read = (op_q == DEBUG_OPX_RD_MEM) || (op_q == DEBUG_OPX_RD_REG) ||
                 (op_q == DEBUG_OPX_RD_CC)  || (op_q == DEBUG_OPX_RD_PC);
  end

  // Pulse outputs default low every cycle; level outputs hold until rewritten.
  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    addr_d        = addr_q;
    argx_d        = argx_q;
    data_d        = data_q;
    cnt_d         = cnt_q;
    debug_ack_d   = 1'b0;
    ld_data_en_d  = 1'b0;
    addr_inc_en_d = 1'b0;
    reg_wr_d      = 1'b0;
    datax_d       = datax_q;
    mem_addr_d    = mem_addr_q;
    mem_dout_d    = mem_dout_q;
    mem_rd_d      = mem_rd_q;
    mem_wr_d      = mem_wr_q;
    reg_addr_d    = reg_addr_q;
    err_d         = err_q;

    case (state_q)
      S_IDLE: begin
        if (DEBUG_REQ && DEBUG_MODE) begin
          op_d    = DEBUG_OP;
          addr_d  = DEBUG_ADDR_OUT;
          argx_d  = DEBUG_ARGX_OUT;
          data_d  = DEBUG_DATA_OUT;
          err_d   = 1'b0;
          state_d = S_EXEC;
        end
      end

      S_EXEC: begin
        cnt_d = '0;
        case (op_q)
          DEBUG_OPX_WR_MEM: begin
            mem_addr_d = addr_q;
            mem_dout_d = data_q;
            mem_wr_d   = 1'b1;
            state_d    = S_MEMWAIT;
          end
          DEBUG_OPX_RD_MEM: begin
            mem_addr_d = addr_q;
            mem_rd_d   = 1'b1;
            datax_d    = DEBUG_DATAX_DIN;
            state_d    = S_MEMWAIT;
          end
          DEBUG_OPX_RD_REG: begin
            reg_addr_d = argx_q;
            datax_d    = DEBUG_DATAX_REGB_DATA;
            state_d    = S_REGWAIT;
          end
          DEBUG_OPX_WR_REG: begin
            reg_addr_d = argx_q;
            reg_wr_d   = 1'b1;
            state_d    = S_ACK;
          end
          DEBUG_OPX_RD_CC: begin
            datax_d = DEBUG_DATAX_CC_DATA;
            state_d = S_ACK;
          end
          DEBUG_OPX_RD_PC: begin
            datax_d = DEBUG_DATAX_PC_A_NEXT;
            state_d = S_ACK;
          end
          default: begin
            state_d = S_ACK;
          end
        endcase
      end

      // A ready arriving on the final allowed cycle still counts as success.
      S_MEMWAIT: begin
        if (MEM_READY) begin
          mem_rd_d = 1'b0;
          mem_wr_d = 1'b0;
          state_d  = S_ACK;
        end else if (cnt_q == CNT_LAST) begin
          mem_rd_d = 1'b0;
          mem_wr_d = 1'b0;
          err_d    = 1'b1;
          state_d  = S_ACK;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_REGWAIT: begin
        state_d = S_ACK;
      end

      S_ACK: begin
        debug_ack_d   = 1'b1;
        ld_data_en_d  = op_is_read;
        addr_inc_en_d = op_is_mem && argx_q[0];
        state_d       = S_RELEASE;
      end

      S_RELEASE: begin
        if (!DEBUG_REQ) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q       <= S_IDLE;
      op_q          <= DEBUG_OPX_NONE;
      addr_q        <= '0;
      argx_q        <= '0;
      data_q        <= '0;
      cnt_q         <= '0;
      debug_ack_q   <= 1'b0;
      ld_data_en_q  <= 1'b0;
      addr_inc_en_q <= 1'b0;
      datax_q       <= DEBUG_DATAX_DIN;
      mem_addr_q    <= '0;
      mem_dout_q    <= '0;
      mem_rd_q      <= 1'b0;
      mem_wr_q      <= 1'b0;
      reg_addr_q    <= '0;
      reg_wr_q      <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      addr_q        <= addr_d;
      argx_q        <= argx_d;
      data_q        <= data_d;
      cnt_q         <= cnt_d;
      debug_ack_q   <= debug_ack_d;
      ld_data_en_q  <= ld_data_en_d;
      addr_inc_en_q <= addr_inc_en_d;
      datax_q       <= datax_d;
      mem_addr_q    <= mem_addr_d;
      mem_dout_q    <= mem_dout_d;
      mem_rd_q      <= mem_rd_d;
      mem_wr_q      <= mem_wr_d;
      reg_addr_q    <= reg_addr_d;
      reg_wr_q      <= reg_wr_d;
      err_q         <= err_d;
    end
  end

  assign DEBUG_ACK         = debug_ack_q;
  assign DEBUG_LD_DATA_EN  = ld_data_en_q;
  assign DEBUG_ADDR_INC_EN = addr_inc_en_q;
  assign DEBUG_DATAX       = datax_q;
  assign MEM_ADDR          = mem_addr_q;
  assign MEM_DOUT          = mem_dout_q;
  assign MEM_RD            = mem_rd_q;
  assign MEM_WR            = mem_wr_q;
  assign REG_ADDR          = reg_addr_q;
  assign REG_WR            = reg_wr_q;
  assign DEBUG_ERR         = err_q;

endmodule

// File: tb/tb_debug_responder.sv
// Self-checking bench for debug_responder: directed scenarios followed by random
// requests, each compared against a per-operation timing/effect model.
module tb_debug_responder;

  localparam int MEM_TIMEOUT = 15;
  localparam int MAXC        = 40;

  localparam logic [3:0] OP_NONE   = 4'h0;
  localparam logic [3:0] OP_WR_MEM = 4'h1;
  localparam logic [3:0] OP_RD_MEM = 4'h2;
  localparam logic [3:0] OP_RD_REG = 4'h3;
  localparam logic [3:0] OP_WR_REG = 4'h4;
  localparam logic [3:0] OP_RD_CC  = 4'h5;
  localparam logic [3:0] OP_RD_PC  = 4'h6;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        DEBUG_MODE;
  logic        DEBUG_REQ;
  logic [3:0]  DEBUG_OP;
  logic [15:0] DEBUG_ADDR_OUT;
  logic [3:0]  DEBUG_ARGX_OUT;
  logic [15:0] DEBUG_DATA_OUT;
  logic        DEBUG_ACK;
  logic        DEBUG_LD_DATA_EN;
  logic [1:0]  DEBUG_DATAX;
  logic        DEBUG_ADDR_INC_EN;
  logic [15:0] MEM_ADDR;
  logic [15:0] MEM_DOUT;
  logic        MEM_RD;
  logic        MEM_WR;
  logic        MEM_READY;
  logic [3:0]  REG_ADDR;
  logic        REG_WR;
  logic        DEBUG_ERR;

  int checks = 0;
  int errors = 0;
  logic [1:0] modelDatax = 2'd0;

  debug_responder #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(4)) dut (
    .CLK(CLK), .RESET(RESET), .DEBUG_MODE(DEBUG_MODE), .DEBUG_REQ(DEBUG_REQ),
    .DEBUG_OP(DEBUG_OP), .DEBUG_ADDR_OUT(DEBUG_ADDR_OUT), .DEBUG_ARGX_OUT(DEBUG_ARGX_OUT),
    .DEBUG_DATA_OUT(DEBUG_DATA_OUT), .DEBUG_ACK(DEBUG_ACK), .DEBUG_LD_DATA_EN(DEBUG_LD_DATA_EN),
    .DEBUG_DATAX(DEBUG_DATAX), .DEBUG_ADDR_INC_EN(DEBUG_ADDR_INC_EN), .MEM_ADDR(MEM_ADDR),
    .MEM_DOUT(MEM_DOUT), .MEM_RD(MEM_RD), .MEM_WR(MEM_WR), .MEM_READY(MEM_READY),
    .REG_ADDR(REG_ADDR), .REG_WR(REG_WR), .DEBUG_ERR(DEBUG_ERR)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Drives one request (caller is on a falling edge) and checks what the port sees.
  // readyWait: strobe cycle on which memory answers (0 = never).
  task automatic applyStimulus(input string name, input logic [3:0] op, input logic [15:0] addr,
                               input logic [3:0] argx, input logic [15:0] data,
                               input int readyWait, input int holdAfterAck, input bit dropMode);
    int ackCycle = -1;
    int ackCount = 0;
    int ldCount = 0;
    int ldAtAck = 0;
    int incCount = 0;
    int incAtAck = 0;
    int memWrCycles = 0;
    int memRdCycles = 0;
    int regWrCycles = 0;
    int strobeCycles = 0;
    int addrBad = 0;
    int regAddrBad = 0;
    logic [1:0] dataxAtAck = 2'd0;
    logic errAtAck = 1'b0;
    logic [3:0] regAddrAtAck = 4'd0;
    bit isMem, isRead, timedOut;
    int waitCycles, expLat;

    isMem    = (op == OP_WR_MEM) || (op == OP_RD_MEM);
    isRead   = (op == OP_RD_MEM) || (op == OP_RD_REG) || (op == OP_RD_CC) || (op == OP_RD_PC);
    timedOut = isMem && (readyWait == 0 || readyWait > MEM_TIMEOUT);
    waitCycles = !isMem ? 0 : (timedOut ? MEM_TIMEOUT : readyWait);
    expLat   = isMem ? 2 + waitCycles : ((op == OP_RD_REG) ? 3 : 2);
    case (op)
      OP_RD_MEM: modelDatax = 2'd0;
      OP_RD_REG: modelDatax = 2'd1;
      OP_RD_CC:  modelDatax = 2'd2;
      OP_RD_PC:  modelDatax = 2'd3;
      default:   modelDatax = modelDatax;
    endcase

    DEBUG_OP       = op;
    DEBUG_ADDR_OUT = addr;
    DEBUG_ARGX_OUT = argx;
    DEBUG_DATA_OUT = data;
    DEBUG_REQ      = 1'b1;
    MEM_READY      = 1'b0;

    for (int k = 1; k <= MAXC; k++) begin
      @(negedge CLK);
      if (k == 1) begin
        DEBUG_OP       = 4'($urandom);
        DEBUG_ADDR_OUT = 16'($urandom);
        DEBUG_ARGX_OUT = 4'($urandom);
        DEBUG_DATA_OUT = 16'($urandom);
        if (dropMode) DEBUG_MODE = 1'b0;
      end
      if (DEBUG_ACK) begin
        ackCount++;
        if (ackCycle < 0) begin
          ackCycle     = k - 1;
          dataxAtAck   = DEBUG_DATAX;
          errAtAck     = DEBUG_ERR;
          regAddrAtAck = REG_ADDR;
        end
        if (DEBUG_LD_DATA_EN) ldAtAck++;
        if (DEBUG_ADDR_INC_EN) incAtAck++;
      end
      if (DEBUG_LD_DATA_EN) ldCount++;
      if (DEBUG_ADDR_INC_EN) incCount++;
      if (MEM_WR) begin
        memWrCycles++;
        if (MEM_ADDR !== addr || MEM_DOUT !== data) addrBad++;
      end
      if (MEM_RD) begin
        memRdCycles++;
        if (MEM_ADDR !== addr) addrBad++;
      end
      if (REG_WR) begin
        regWrCycles++;
        if (REG_ADDR !== argx) regAddrBad++;
      end
      if (MEM_WR || MEM_RD) strobeCycles++;
      MEM_READY = (MEM_WR || MEM_RD) && readyWait != 0 && strobeCycles == readyWait;
      if (ackCycle >= 0 && k - 1 >= ackCycle + holdAfterAck + 1) break;
      if (ackCycle >= 0 && k - 1 == ackCycle + holdAfterAck) DEBUG_REQ = 1'b0;
    end
    DEBUG_REQ  = 1'b0;
    DEBUG_MODE = 1'b1;
    MEM_READY  = 1'b0;

    checkOutput({name, "_latency"}, 32'(ackCycle), 32'(expLat));
    checkOutput({name, "_ack_count"}, 32'(ackCount), 32'd1);
    checkOutput({name, "_ld_count"}, 32'(ldCount), 32'(isRead));
    checkOutput({name, "_ld_at_ack"}, 32'(ldAtAck), 32'(isRead));
    checkOutput({name, "_inc_count"}, 32'(incCount), 32'(isMem && argx[0]));
    checkOutput({name, "_inc_at_ack"}, 32'(incAtAck), 32'(isMem && argx[0]));
    checkOutput({name, "_mem_wr_cycles"}, 32'(memWrCycles), 32'((op == OP_WR_MEM) ? waitCycles : 0));
    checkOutput({name, "_mem_rd_cycles"}, 32'(memRdCycles), 32'((op == OP_RD_MEM) ? waitCycles : 0));
    checkOutput({name, "_reg_wr_cycles"}, 32'(regWrCycles), 32'(op == OP_WR_REG));
    checkOutput({name, "_mem_bus_bad"}, 32'(addrBad), 32'd0);
    checkOutput({name, "_reg_addr_bad"}, 32'(regAddrBad), 32'd0);
    checkOutput({name, "_datax"}, 32'(dataxAtAck), 32'(modelDatax));
    checkOutput({name, "_err"}, 32'(errAtAck), 32'(timedOut));
    if (op == OP_RD_REG || op == OP_WR_REG)
      checkOutput({name, "_reg_addr"}, 32'(regAddrAtAck), 32'(argx));
  endtask

  initial begin
    int strobeSeen;
    int ackSeen;
    logic [3:0] rop;
    int rwait;

    RESET = 1'b1;
    DEBUG_MODE = 1'b0;
    DEBUG_REQ = 1'b0;
    DEBUG_OP = 4'h0;
    DEBUG_ADDR_OUT = 16'h0;
    DEBUG_ARGX_OUT = 4'h0;
    DEBUG_DATA_OUT = 16'h0;
    MEM_READY = 1'b0;
    repeat (3) @(negedge CLK);
    checkOutput("rst_ack", 32'(DEBUG_ACK), 32'd0);
    checkOutput("rst_ld", 32'(DEBUG_LD_DATA_EN), 32'd0);
    checkOutput("rst_inc", 32'(DEBUG_ADDR_INC_EN), 32'd0);
    checkOutput("rst_datax", 32'(DEBUG_DATAX), 32'd0);
    checkOutput("rst_mem_rd", 32'(MEM_RD), 32'd0);
    checkOutput("rst_mem_wr", 32'(MEM_WR), 32'd0);
    checkOutput("rst_mem_addr", 32'(MEM_ADDR), 32'd0);
    checkOutput("rst_mem_dout", 32'(MEM_DOUT), 32'd0);
    checkOutput("rst_reg_wr", 32'(REG_WR), 32'd0);
    checkOutput("rst_reg_addr", 32'(REG_ADDR), 32'd0);
    checkOutput("rst_err", 32'(DEBUG_ERR), 32'd0);
    RESET = 1'b0;

    $display("[TB] requests with core running must be ignored");
    DEBUG_OP = OP_WR_MEM;
    DEBUG_REQ = 1'b1;
    strobeSeen = 0;
    ackSeen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (DEBUG_ACK) ackSeen++;
      if (MEM_WR || MEM_RD || REG_WR) strobeSeen++;
    end
    checkOutput("mode0_ack", 32'(ackSeen), 32'd0);
    checkOutput("mode0_strobes", 32'(strobeSeen), 32'd0);
    DEBUG_REQ = 1'b0;
    DEBUG_MODE = 1'b1;
    @(negedge CLK);

    $display("[TB] directed operations");
    applyStimulus("wr_mem", OP_WR_MEM, 16'h5678, 4'h1, 16'h1234, 2, 0, 1'b0);
    applyStimulus("rd_reg", OP_RD_REG, 16'h0000, 4'h3, 16'h0000, 0, 0, 1'b0);
    applyStimulus("rd_cc", OP_RD_CC, 16'h0000, 4'h0, 16'h0000, 0, 0, 1'b0);
    applyStimulus("rd_pc", OP_RD_PC, 16'h0000, 4'h0, 16'h0000, 0, 0, 1'b0);
    applyStimulus("rd_mem_timeout", OP_RD_MEM, 16'h00A0, 4'h1, 16'h0000, 0, 0, 1'b0);
    checkOutput("err_sticky", 32'(DEBUG_ERR), 32'd1);
    applyStimulus("wr_reg_clr_err", OP_WR_REG, 16'h0000, 4'h7, 16'h55AA, 0, 0, 1'b0);
    applyStimulus("rd_mem_first", OP_RD_MEM, 16'hFFFE, 4'h0, 16'h0000, 1, 0, 1'b0);
    applyStimulus("rd_mem_last", OP_RD_MEM, 16'h1000, 4'h1, 16'h0000, MEM_TIMEOUT, 0, 1'b0);
    applyStimulus("hold_req", OP_RD_CC, 16'h0000, 4'h0, 16'h0000, 0, 10, 1'b0);
    applyStimulus("after_hold", OP_RD_PC, 16'h0000, 4'h0, 16'h0000, 0, 0, 1'b0);
    applyStimulus("op_none", OP_NONE, 16'h1111, 4'h1, 16'h2222, 0, 0, 1'b0);
    applyStimulus("op_undef", 4'hC, 16'h3333, 4'h1, 16'h4444, 0, 0, 1'b0);
    applyStimulus("mode_drop", OP_WR_MEM, 16'h0042, 4'h0, 16'hCAFE, 3, 0, 1'b1);

    $display("[TB] reset during memory wait");
    DEBUG_OP = OP_RD_MEM;
    DEBUG_ADDR_OUT = 16'h0BAD;
    DEBUG_REQ = 1'b1;
    repeat (4) @(negedge CLK);
    checkOutput("rst_mid_pre_rd", 32'(MEM_RD), 32'd1);
    #2 RESET = 1'b1;
    #1 checkOutput("rst_mid_async_rd", 32'(MEM_RD), 32'd0);
    checkOutput("rst_mid_ack", 32'(DEBUG_ACK), 32'd0);
    DEBUG_REQ = 1'b0;
    modelDatax = 2'd0;
    ackSeen = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      if (DEBUG_ACK || MEM_RD) ackSeen++;
    end
    RESET = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      if (DEBUG_ACK || MEM_RD) ackSeen++;
    end
    checkOutput("rst_mid_quiet", 32'(ackSeen), 32'd0);
    applyStimulus("wr_reg_beef", OP_WR_REG, 16'h0000, 4'h5, 16'hBEEF, 0, 0, 1'b0);

    $display("[TB] random operations");
    for (int n = 0; n < 40; n++) begin
      rop = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) != 0) rop = 4'($urandom_range(0, 6));
      rwait = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 1) * 16 : $urandom_range(1, 6);
      applyStimulus("rand", rop, 16'($urandom), 4'($urandom), 16'($urandom), rwait,
                    $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/debug_responder.md
Name: debug_responder

Overview:
- CPU-side end of the debug request channel: consumes DEBUG_REQ/DEBUG_OP/DEBUG_ADDR_OUT/DEBUG_ARGX_OUT/DEBUG_DATA_OUT from the debug port and executes the operation against memory, the register file and the CC/PC sources.
- Returns DEBUG_ACK, DEBUG_LD_DATA_EN, DEBUG_DATAX and DEBUG_ADDR_INC_EN to the debug port.
- Sits between the debug port and the core datapath; acts only while the core is stopped (DEBUG_MODE=1).

Parameters:
- MEM_TIMEOUT, 15, max cycles to wait for MEM_READY before forcing completion with error.
- CNT_W, 4, width of timeout counter (must hold MEM_TIMEOUT).

Ports:
- CLK  in  1  system clock, rising edge.
- RESET  in  1  reset; one clock; reset is asynchronous and active-high.
- DEBUG_MODE  in  1  1 = core stopped, requests may execute.
- DEBUG_REQ  in  1  level request from debug port.
- DEBUG_OP  in  4  operation code (DEBUG_OPX_* constants).
- DEBUG_ADDR_OUT  in  16  memory address for memory ops.
- DEBUG_ARGX_OUT  in  4  register index; bit0 also = auto-increment flag for memory ops.
- DEBUG_DATA_OUT  in  16  write data.
- DEBUG_ACK  out  1  one-cycle completion pulse.
- DEBUG_LD_DATA_EN  out  1  one-cycle load strobe for the debug port data register, coincident with ACK.
- DEBUG_DATAX  out  2  data source select (DEBUG_DATAX_DIN/REGB_DATA/CC_DATA/PC_A_NEXT).
- DEBUG_ADDR_INC_EN  out  1  one-cycle address increment strobe, coincident with ACK.
- MEM_ADDR  out  16  memory address.
- MEM_DOUT  out  16  memory write data.
- MEM_RD  out  1  memory read strobe (held until ready/timeout).
- MEM_WR  out  1  memory write strobe (held until ready/timeout).
- MEM_READY  in  1  memory access complete.
- REG_ADDR  out  4  register file index.
- REG_WR  out  1  register write strobe, one cycle.
- DEBUG_ERR  out  1  sticky: last memory op timed out; cleared on next accepted request.

Behaviour:
- Reset: all outputs 0, DEBUG_DATAX = DEBUG_DATAX_DIN, state IDLE, counter 0.
- States: IDLE, EXEC, MEMWAIT, REGWAIT, ACK, RELEASE.
- IDLE: when DEBUG_REQ=1 and DEBUG_MODE=1, latch OP/ADDR/ARGX/DATA, clear DEBUG_ERR, go EXEC. DEBUG_MODE=0: requests ignored, no ACK ever issued.
- EXEC decode:
  - WR_MEM: MEM_ADDR/MEM_DOUT from latches, MEM_WR=1, go MEMWAIT.
  - RD_MEM: MEM_RD=1, DATAX=DIN, go MEMWAIT.
  - RD_REG: REG_ADDR=ARGX, DATAX=REGB_DATA, go REGWAIT.
  - WR_REG: REG_ADDR=ARGX, REG_WR pulse 1 cycle, go ACK.
  - RD_CC: DATAX=CC_DATA, go ACK with load.
  - RD_PC: DATAX=PC_A_NEXT, go ACK with load.
  - NONE / undefined codes: go ACK, no side effects, no load.
- MEMWAIT: strobe held; counter increments each cycle. MEM_READY=1 → drop strobe, go ACK. Counter reaches MEM_TIMEOUT → drop strobe, set DEBUG_ERR, go ACK (LD_DATA_EN still asserted for RD_MEM; data undefined).
- REGWAIT: exactly 1 cycle for register file read latency, then ACK.
- ACK: DEBUG_ACK=1 for one cycle. LD_DATA_EN=1 same cycle for RD_MEM/RD_REG/RD_CC/RD_PC. ADDR_INC_EN=1 same cycle for WR_MEM/RD_MEM when latched ARGX[0]=1 (increments from port, +2). Then RELEASE.
- RELEASE: wait for DEBUG_REQ=0 before returning to IDLE; a REQ held high never triggers a second execution.
- DEBUG_DATAX holds its last value from EXEC until the next EXEC.
- Latency from REQ rising (sampled) to ACK: WR_REG/RD_CC/RD_PC/NONE 2 cycles; RD_REG 3; memory ops 3 + wait cycles (MEM_READY in first MEMWAIT cycle → 3).
- DEBUG_MODE falling mid-operation: current op completes normally.
- RESET mid-operation: immediate return to IDLE, all strobes low, pending ACK lost.

Test Plan:
- Reset → all outputs 0, DATAX=DIN; REQ=1 with DEBUG_MODE=0 for 20 cycles → no ACK, no MEM/REG strobes.
- WR_MEM addr 0x5678 data 0x1234, ARGX=1, MEM_READY on 2nd wait cycle → MEM_WR high 2 cycles with MEM_ADDR=0x5678, MEM_DOUT=0x1234; ACK+ADDR_INC_EN one cycle, no LD_DATA_EN, DEBUG_ERR=0.
- RD_REG ARGX=3 → REG_ADDR=3, DATAX=REGB_DATA, ACK+LD_DATA_EN at cycle 3; repeat RD_CC → DATAX=CC_DATA; RD_PC → DATAX=PC_A_NEXT, ACK at cycle 2.
- RD_MEM, MEM_READY never asserted → MEM_RD high exactly MEM_TIMEOUT cycles, then ACK+LD_DATA_EN, DEBUG_ERR=1; next request clears DEBUG_ERR.
- REQ held high 10 cycles after ACK → exactly one ACK; REQ low 1 cycle then high → second op executes.
- RESET asserted during MEMWAIT → MEM_RD drops asynchronously, no ACK; after release, new WR_REG ARGX=5 data 0xBEEF → REG_WR one cycle, REG_ADDR=5, ACK.
